// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters
// Fetch prediction is combinational; decode allocates, execute trains two cycles later.
module branch_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic              d_is_branch,
  input  logic              x_predict_res,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];

  logic              s0_v_q, s1_v_q;
  logic [ADDR_W-1:0] s0_pc_q, s1_pc_q;

  logic [IDX_W-1:0] f_idx, d_idx, x_idx;
  logic             f_hit, d_hit, x_hit, d_alloc, x_drop;
  logic [1:0]       ctr_x_d;

  assign f_idx = f_pc[IDX_W-1:0];
  assign d_idx = d_pc[IDX_W-1:0];
  assign x_idx = s1_pc_q[IDX_W-1:0];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_pc[ADDR_W-1:IDX_W]);
  assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_pc[ADDR_W-1:IDX_W]);
  assign x_hit = s1_v_q && valid_q[x_idx] && (tag_q[x_idx] == s1_pc_q[ADDR_W-1:IDX_W]);

  assign f_predict_valid = f_hit && ctr_q[f_idx][1];
  assign f_predict_addr  = f_predict_valid ? tgt_q[f_idx] : f_pc + ADDR_W'(1);

  // A decode replacement on the index being trained discards the stale outcome.
  assign d_alloc = d_is_branch && !d_hit;
  assign x_drop  = d_alloc && (d_idx == x_idx);

  always_comb begin
    ctr_x_d = ctr_q[x_idx];
    if (x_predict_res) begin
      if (ctr_q[x_idx] != 2'b11) ctr_x_d = ctr_q[x_idx] + 2'b01;
    end else begin
      if (ctr_q[x_idx] != 2'b00) ctr_x_d = ctr_q[x_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
      s0_v_q  <= 1'b0;
      s0_pc_q <= '0;
      s1_v_q  <= 1'b0;
      s1_pc_q <= '0;
    end else begin
      s0_v_q  <= d_is_branch;
      s0_pc_q <= d_pc;
      s1_v_q  <= s0_v_q;
      s1_pc_q <= s0_pc_q;

      if (x_hit && !x_drop) ctr_q[x_idx] <= ctr_x_d;

      if (d_is_branch) begin
        tgt_q[d_idx] <= target_addr;
        if (!d_hit) begin
          valid_q[d_idx] <= 1'b1;
          tag_q[d_idx]   <= d_pc[ADDR_W-1:IDX_W];
          ctr_q[d_idx]   <= 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] target_addr = '0;
  logic [31:0] f_pc = '0;
  logic [31:0] d_pc = '0;
  logic        d_is_branch = 1'b0;
  logic        x_predict_res = 1'b0;
  logic [31:0] f_predict_addr;
  logic        f_predict_valid;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  branch_predictor #(.ADDR_W(32), .IDX_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .target_addr(target_addr),
    .f_pc(f_pc),
    .d_pc(d_pc),
    .d_is_branch(d_is_branch),
    .x_predict_res(x_predict_res),
    .f_predict_addr(f_predict_addr),
    .f_predict_valid(f_predict_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic br, input logic [31:0] dpc, input logic [31:0] tgt,
                       input logic xr, input logic [31:0] fpc);
    @(posedge clk);
    #1;
    d_is_branch   = br;
    d_pc          = dpc;
    target_addr   = tgt;
    x_predict_res = xr;
    f_pc          = fpc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_is_branch = 1'b0;
    x_predict_res = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Decode a branch, then deliver its outcome two cycles later.
  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic res);
    drive(1'b1, pc, tgt, 1'b0, 32'h1000);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h1000);
    drive(1'b0, 32'h0, 32'h0, res, 32'h1000);
  endtask

  task automatic test_reset();
    for (int p = 0; p < 32; p++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'(p));
      exp_q.push_back('{1'b0, 32'(p + 1)});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
        failures++;
        $display("FAIL reset_sweep pc=%h: got v=%0b a=%h, want v=%0b a=%h",
                 f_pc, f_predict_valid, f_predict_addr, e.v, e.a);
      end
    end
  endtask

  task automatic test_taken();
    logic [31:0] pcs [2];
    exp_t        want [2];
    pcs[0] = 32'h10; want[0] = '{1'b1, 32'h40};
    pcs[1] = 32'h11; want[1] = '{1'b0, 32'h12};
    do_reset();
    train(32'h10, 32'h40, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, pcs[k]);
      exp_q.push_back(want[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
        failures++;
        $display("FAIL taken pc=%h: got v=%0b a=%h, want v=%0b a=%h",
                 f_pc, f_predict_valid, f_predict_addr, e.v, e.a);
      end
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    train(32'h10, 32'h40, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
    exp_q.push_back('{1'b0, 32'h11});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL not_taken: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
  endtask

  task automatic test_saturation();
    // counter after each outcome: 10 11 11 10 01 00 00 00 01 10
    logic res [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic tk  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      train(32'h10, 32'h40, res[k]);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
      exp_q.push_back('{tk[k], tk[k] ? 32'h40 : 32'h11});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
        failures++;
        $display("FAIL saturation step=%0d: got v=%0b a=%h, want v=%0b a=%h",
                 k, f_predict_valid, f_predict_addr, e.v, e.a);
      end
    end
  endtask

  task automatic test_alias();
    do_reset();
    train(32'h10, 32'h40, 1'b1);
    drive(1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
    drive(1'b1, 32'h20, 32'h80, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    exp_q.push_back('{1'b0, 32'h11});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL alias_evict: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h20);
    exp_q.push_back('{1'b0, 32'h21});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL alias_stale_train: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
  endtask

  task automatic test_same_index();
    // decode miss on the trained index: new entry wins, starts at 01
    do_reset();
    train(32'h10, 32'h40, 1'b1);
    drive(1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 32'h30, 32'h90, 1'b1, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h30);
    exp_q.push_back('{1'b0, 32'h31});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL same_idx_miss: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
    // decode hit on the trained index: both target and counter update apply
    do_reset();
    train(32'h10, 32'h40, 1'b1);
    drive(1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 32'h10, 32'h50, 1'b1, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
    exp_q.push_back('{1'b1, 32'h50});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL same_idx_hit_tgt: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
    exp_q.push_back('{1'b1, 32'h50});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL same_idx_hit_ctr: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    logic        br, xr;
    do_reset();
    // Branch every 4th PC, taken feedback two cycles later, fetch lagging decode by 4.
    for (int i = 0; i < 36; i++) begin
      p  = 32'(i) - 32'd4;
      br = (i < 32) && (i % 4 == 0);
      xr = (i >= 2) && (i - 2 < 32) && ((i - 2) % 4 == 0);
      drive(br, 32'(i), 32'(i) + 32'h100, xr, p);
      if (i >= 4 && (p % 4 == 0)) exp_q.push_back('{1'b1, p + 32'h100});
      else                        exp_q.push_back('{1'b0, p + 32'd1});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
        failures++;
        $display("FAIL periodic i=%0d pc=%h: got v=%0b a=%h, want v=%0b a=%h",
                 i, f_pc, f_predict_valid, f_predict_addr, e.v, e.a);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
    exp_q.push_back('{1'b1, 32'h110});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL pre_async_rst: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
    #1;
    rst = 1'b1;
    exp_q.push_back('{1'b0, 32'h11});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
      failures++;
      $display("FAIL async_rst: got v=%0b a=%h, want v=%0b a=%h",
               f_predict_valid, f_predict_addr, e.v, e.a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int q = 0; q < 32; q++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'(q));
      exp_q.push_back('{1'b0, 32'(q + 1)});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (f_predict_valid !== e.v || f_predict_addr !== e.a) begin
        failures++;
        $display("FAIL post_rst_miss pc=%h: got v=%0b a=%h, want v=%0b a=%h",
                 f_pc, f_predict_valid, f_predict_addr, e.v, e.a);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_taken();
    test_not_taken();
    test_saturation();
    test_alias();
    test_same_index();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits beside the fetch stage. Each cycle it combinationally predicts, for the PC being fetched, whether the instruction is a taken branch and where it goes.
- Entries are allocated from the decode stage and trained by execute-stage feedback, which arrives two cycles after decode.

Parameters:
- ADDR_W, 32, width of all PC/address buses.
- IDX_W, 4, log2 of entry count (16 entries); index = pc[IDX_W-1:0], tag = pc[ADDR_W-1:IDX_W].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- target_addr  input  ADDR_W  branch target of the instruction in decode; sampled when d_is_branch=1.
- f_pc  input  ADDR_W  PC currently being fetched.
- d_pc  input  ADDR_W  PC of the instruction in decode.
- d_is_branch  input  1  decode instruction is a branch; allocate or refresh its entry.
- x_predict_res  input  1  execute outcome of the branch that was in decode two cycles earlier: 1 = taken, 0 = not taken.
- f_predict_addr  output  ADDR_W  predicted next PC for f_pc.
- f_predict_valid  output  1  1 = predicted taken, redirect fetch to f_predict_addr.

Behaviour:
- Storage per entry: valid bit, tag (ADDR_W-IDX_W bits), target (ADDR_W bits), 2-bit counter.
  - Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (async, rst=1):
  - Clear all valid bits.
  - Set all counters to 01.
  - Clear the tracking pipeline.
  - Takes effect immediately, mid-operation included.
- Prediction (combinational, zero latency):
  - hit = valid[idx(f_pc)] && tag match.
  - f_predict_valid = hit && counter[1].
  - f_predict_addr = stored target when f_predict_valid, else f_pc+1 (wraps modulo 2^ADDR_W).
  - During/after reset: f_predict_valid=0, f_predict_addr=f_pc+1.
- Decode allocation (posedge, when d_is_branch=1):
  - Miss at idx(d_pc): write valid=1, tag(d_pc), target_addr, counter=01. Any aliased entry is overwritten.
  - Hit: overwrite target with target_addr; counter unchanged.
- Tracking pipeline:
  - Two-stage shift register of {valid, pc}.
  - Stage0 <= {d_is_branch, d_pc}; stage1 <= stage0 each cycle.
  - stage1 is the branch whose outcome is on x_predict_res this cycle.
- Execute training (posedge, when stage1.valid=1):
  - If the entry at idx(stage1.pc) is valid and the tag matches:
    - x_predict_res=1: counter saturating +1 (11 stays 11).
    - x_predict_res=0: counter saturating -1 (00 stays 00).
  - If the entry was evicted or invalidated: no update.
  - When stage1.valid=0, x_predict_res is ignored.
- Simultaneous decode and execute on the same index in one cycle:
  - Decode miss-replacement wins (new entry, counter=01); training is dropped.
  - Decode hit: target from decode and counter update from execute both apply.
- Prediction reads the array state before the edge. A write in cycle N is visible to fetch from cycle N+1.

Test Plan:
- Reset, then sweep f_pc 0..31 with no branches -> f_predict_valid=0 and f_predict_addr=f_pc+1 every cycle.
- d_pc=0x10, d_is_branch=1, target_addr=0x40; two cycles later x_predict_res=1; then f_pc=0x10 -> f_predict_valid=1, f_predict_addr=0x40. f_pc=0x11 -> valid=0, addr=0x12.
- Same allocation but x_predict_res=0 at the execute slot -> counter 00; f_pc=0x10 -> valid=0, addr=0x11.
- Saturation on 0x10:
  - 3 taken outcomes -> 11.
  - 1 not-taken -> 10, still predicts 0x40.
  - 2nd not-taken -> 01, f_predict_valid=0.
  - 3 more not-taken -> stays 00.
  - 1 taken -> 01, still no prediction.
- Alias: train 0x10 taken, then allocate d_pc=0x20 (same index 0) with target 0x80 -> f_pc=0x10 gives valid=0. Feedback for a stale 0x10 in stage1 does not change the 0x20 counter.
- Periodic run: PC increments by 1 each cycle, branch every 4th decode, taken feedback 2 cycles later. Then assert rst asynchronously mid-cycle -> f_predict_valid drops to 0 immediately, and all prior entries miss after rst deasserts.
